// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state/op encodings and default widths for the MAR/MDR memory-access controller
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// rtl/mem_access_ctrl_wait_counter.sv - loadable wait-state down-counter with zero flag
module wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero so a stalled ACCESS never wraps back to a large count.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR memory-access controller with wait states
// Optional ready-handshake completion with timeout: MEM_READY_EN
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              MAR_enable,
  input  logic              MDR_enable,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
`ifdef MEM_READY_EN
  output logic              timeout,
`endif
  output logic              conflict
);

  state_t            state, state_d;
  op_t               op_q, op_d;
  logic              first_q;
  logic [DATA_W-1:0] mar_q, mdr_q;
  logic              conflict_q;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              capture;
  logic              accept;

  assign accept = (state == IDLE) && (rd_req || wr_req);

  wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef MEM_READY_EN
  logic timed_out;
  logic timeout_q;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
`endif

  always_comb begin
    state_d  = state;
    op_d     = op_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
`ifdef MEM_READY_EN
    timed_out = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_d  = ACCESS;
          cnt_load = 1'b1;
          // A simultaneous read and write resolves to the read.
          op_d     = rd_req ? OP_RD : OP_WR;
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
`ifdef MEM_READY_EN
        capture   = (op_q == OP_RD) && mem_ready;
        timed_out = cnt_zero && !mem_ready;
        if (mem_ready || cnt_zero) state_d = DONE;
`else
        capture = (op_q == OP_RD) && cnt_zero;
        if (cnt_zero) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      op_q       <= OP_RD;
      first_q    <= 1'b0;
      mar_q      <= '0;
      mdr_q      <= '0;
      conflict_q <= 1'b0;
`ifdef MEM_READY_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      first_q    <= accept;
      conflict_q <= (state == IDLE) && rd_req && wr_req;
`ifdef MEM_READY_EN
      timeout_q  <= timed_out;
`endif
      if (state == IDLE) begin
        if (MAR_enable) mar_q <= bus_data;
        if (MDR_enable) mdr_q <= bus_data;
      end
      if (capture) mdr_q <= mem_rdata;
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q[ADDR_W-1:0];
  assign mem_wdata = mdr_q;
  assign mem_re    = (state == ACCESS) && (op_q == OP_RD);
  // The write strobe is a single pulse; the remaining cycles are RAM hold time.
  assign mem_we    = (state == ACCESS) && (op_q == OP_WR) && first_q;
  assign busy      = (state == ACCESS);
  assign done      = (state == DONE);
  assign conflict  = conflict_q;
`ifdef MEM_READY_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int WS = 2;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // main instance, WAIT_STATES=2
  logic [31:0] bus = '0;
  logic        mar_en = 0, mdr_en = 0, rd = 0, wr = 0;
  logic [31:0] rdata_q;
  logic        ready_main;
  logic [31:0] mar_out, mdr_out, mem_wdata;
  logic [7:0]  mem_addr;
  logic        mem_re, mem_we, busy, done, conflict;
  logic        timeout_m;

  // single-cycle instance, WAIT_STATES=0
  logic [31:0] bus0 = '0;
  logic        mar_en0 = 0, mdr_en0 = 0, rd0 = 0, wr0 = 0;
  logic [31:0] rdata0;
  logic [31:0] mar_out0, mdr_out0, mem_wdata0;
  logic [7:0]  mem_addr0;
  logic        mem_re0, mem_we0, busy0, done0, conflict0;
  logic        timeout0;

  logic [31:0] ram [0:255];
  logic        ram_loaded = 1'b0;
  int          acc_cycles = 0;
  int          done_cnt = 0, we_cnt = 0, conf_cnt = 0;
  int          d0, w0, c0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[8'h78] <= 32'hDEAD_BEEF;
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_re) rdata_q <= ram[mem_addr];
    acc_cycles <= busy ? acc_cycles + 1 : 0;
  end

  assign rdata0 = ram[mem_addr0];

`ifdef MEM_READY_EN
  assign ready_main = busy && (acc_cycles == WS);
`else
  assign ready_main = 1'b0;
  assign timeout_m  = 1'b0;
  assign timeout0   = 1'b0;
`endif

  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (mem_we)   we_cnt++;
    if (conflict) conf_cnt++;
  end

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(WS), .CNT_W(4)) u_dut (
    .clock(clk), .clear(clear), .bus_data(bus), .MAR_enable(mar_en), .MDR_enable(mdr_en),
    .rd_req(rd), .wr_req(wr), .mem_rdata(rdata_q), .mem_ready(ready_main),
    .mar_out(mar_out), .mdr_out(mdr_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .busy(busy), .done(done),
`ifdef MEM_READY_EN
    .timeout(timeout_m),
`endif
    .conflict(conflict)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0), .CNT_W(4)) u_dut0 (
    .clock(clk), .clear(clear), .bus_data(bus0), .MAR_enable(mar_en0), .MDR_enable(mdr_en0),
    .rd_req(rd0), .wr_req(wr0), .mem_rdata(rdata0), .mem_ready(1'b1),
    .mar_out(mar_out0), .mdr_out(mdr_out0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_re(mem_re0), .mem_we(mem_we0), .busy(busy0), .done(done0),
`ifdef MEM_READY_EN
    .timeout(timeout0),
`endif
    .conflict(conflict0)
  );

`ifdef MEM_READY_EN
  logic [31:0] bus_r = '0;
  logic        mar_en_r = 0, mdr_en_r = 0, rd_r = 0, ready_r = 0;
  logic [31:0] rdata_r;
  logic [31:0] mar_out_r, mdr_out_r, mem_wdata_r;
  logic [7:0]  mem_addr_r;
  logic        mem_re_r, mem_we_r, busy_r, done_r, conflict_r, timeout_r;
  assign rdata_r = ram[mem_addr_r];

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(4), .CNT_W(4)) u_dut_rdy (
    .clock(clk), .clear(clear), .bus_data(bus_r), .MAR_enable(mar_en_r), .MDR_enable(mdr_en_r),
    .rd_req(rd_r), .wr_req(1'b0), .mem_rdata(rdata_r), .mem_ready(ready_r),
    .mar_out(mar_out_r), .mdr_out(mdr_out_r), .mem_addr(mem_addr_r), .mem_wdata(mem_wdata_r),
    .mem_re(mem_re_r), .mem_we(mem_we_r), .busy(busy_r), .done(done_r),
    .timeout(timeout_r), .conflict(conflict_r)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mar", mar_out, 0);
    check("rst_mdr", mdr_out, 0);
    check("rst_re", mem_re, 0);
    check("rst_we", mem_we, 0);
    check("rst_conflict", conflict, 0);
    check("rst_timeout", timeout_m, 0);
    clear = 0;

    // reset in the middle of a read aborts with no capture or done
    bus = 32'h78; mar_en = 1; rd = 1;
    tick();
    mar_en = 0; rd = 0;
    check("abort_busy", busy, 1);
    check("abort_re", mem_re, 1);
    d0 = done_cnt;
    tick();
    #2 clear = 1;
    #1;
    check("abort_re_low", mem_re, 0);
    check("abort_busy_low", busy, 0);
    check("abort_mdr", mdr_out, 0);
    check("abort_mar", mar_out, 0);
    tick();
    clear = 0;
    tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);

    // read: MAR load and request on the same edge
    bus = 32'h0000_0078; mar_en = 1; rd = 1;
    tick();
    mar_en = 0; rd = 0; bus = 0;
    check("rd_addr", mem_addr, 8'h78);
    check("rd_re1", mem_re, 1);
    check("rd_busy1", busy, 1);
    tick();
    check("rd_re2", mem_re, 1);
    tick();
    check("rd_re3", mem_re, 1);
    check("rd_done_early", done, 0);
    tick();
    check("rd_done", done, 1);
    check("rd_busy_done", busy, 0);
    check("rd_re_done", mem_re, 0);
    check("rd_mdr", mdr_out, 32'hDEAD_BEEF);
    tick();
    check("rd_done_once", done, 0);

    // write
    bus = 32'h05; mar_en = 1;
    tick();
    mar_en = 0; bus = 32'h1234_5678; mdr_en = 1; wr = 1;
    tick();
    mdr_en = 0; wr = 0; bus = 0;
    check("wr_we1", mem_we, 1);
    check("wr_busy1", busy, 1);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    check("wr_addr", mem_addr, 8'h05);
    tick();
    check("wr_we2", mem_we, 0);
    check("wr_busy2", busy, 1);
    tick();
    check("wr_busy3", busy, 1);
    check("wr_done_early", done, 0);
    tick();
    check("wr_done", done, 1);
    check("wr_busy_done", busy, 0);
    tick();
    bus = 32'h0; mdr_en = 1; rd = 1;
    tick();
    mdr_en = 0; rd = 0;
    check("rb_mdr_loaded", mdr_out, 0);
    tick(); tick(); tick();
    check("rb_done", done, 1);
    check("rb_mdr", mdr_out, 32'h1234_5678);
    tick();

    // conflict and address truncation
    bus = 32'h0000_0105; mar_en = 1;
    tick();
    mar_en = 0; bus = 0;
    w0 = we_cnt; c0 = conf_cnt;
    rd = 1; wr = 1;
    tick();
    rd = 0; wr = 0;
    check("cf_pulse", conflict, 1);
    check("cf_addr", mem_addr, 8'h05);
    check("cf_mar", mar_out, 32'h0000_0105);
    check("cf_re", mem_re, 1);
    check("cf_we", mem_we, 0);
    tick();
    check("cf_pulse_end", conflict, 0);
    tick(); tick();
    check("cf_done", done, 1);
    check("cf_mdr", mdr_out, 32'h1234_5678);
    check("cf_no_write", we_cnt - w0, 0);
    check("cf_once", conf_cnt - c0, 1);
    tick();

    // loads and requests ignored while busy
    d0 = done_cnt;
    bus = 32'hAAAA_5555; mdr_en = 1; rd = 1;
    tick();
    bus = 32'hFFFF_FFFF; mar_en = 1; mdr_en = 1; rd = 1;
    tick(); tick(); tick();
    check("ig_done", done, 1);
    check("ig_mar", mar_out, 32'h0000_0105);
    check("ig_mdr", mdr_out, 32'h1234_5678);
    tick();
    mar_en = 0; mdr_en = 0; rd = 0; bus = 0;
    check("ig_idle_busy", busy, 0);
    check("ig_idle_done", done, 0);
    tick();
    check("ig_no_restart", busy, 0);
    check("ig_one_done", done_cnt - d0, 1);
    check("ig_mar_hold", mar_out, 32'h0000_0105);

    // zero wait states: single-cycle ACCESS
    bus0 = 32'h78; mar_en0 = 1; rd0 = 1;
    tick();
    mar_en0 = 0; rd0 = 0;
    check("ws0_busy", busy0, 1);
    check("ws0_re", mem_re0, 1);
    tick();
    check("ws0_done", done0, 1);
    check("ws0_busy_low", busy0, 0);
    check("ws0_mdr", mdr_out0, 32'hDEAD_BEEF);
    tick();
    bus0 = 32'hCAFE_0001; mdr_en0 = 1; wr0 = 1;
    tick();
    mdr_en0 = 0; wr0 = 0;
    check("ws0_we", mem_we0, 1);
    check("ws0_wdata", mem_wdata0, 32'hCAFE_0001);
    tick();
    check("ws0_wr_done", done0, 1);
    check("ws0_we_low", mem_we0, 0);
    tick();

`ifdef MEM_READY_EN
    // ready in the second ACCESS cycle completes early with data
    bus_r = 32'h78; mar_en_r = 1; rd_r = 1;
    tick();
    mar_en_r = 0; rd_r = 0;
    tick();
    ready_r = 1;
    tick();
    ready_r = 0;
    check("rdy_done", done_r, 1);
    check("rdy_mdr", mdr_out_r, 32'hDEAD_BEEF);
    check("rdy_no_timeout", timeout_r, 0);
    tick();
    // no ready: timeout after five ACCESS cycles, MDR untouched
    bus_r = 32'h1111_1111; mdr_en_r = 1; rd_r = 1;
    tick();
    mdr_en_r = 0; rd_r = 0;
    tick(); tick(); tick(); tick();
    check("to_busy5", busy_r, 1);
    check("to_done_early", done_r, 0);
    tick();
    check("to_done", done_r, 1);
    check("to_timeout", timeout_r, 1);
    check("to_mdr", mdr_out_r, 32'h1111_1111);
    tick();
    check("to_timeout_end", timeout_r, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised MAR/MDR memory-access controller. It replaces the fixed 32-bit MAR register and single-cycle MDR path that feed the datapath RAM. It latches the address and write data from the datapath bus, then runs a read or write transaction against a synchronous RAM with a configurable number of wait states. It signals busy/done to the control unit and presents the MDR value back to the bus mux.

Parameters:
DATA_W, 32, width of bus, MAR, MDR and RAM data
ADDR_W, 8, RAM address width; mem_addr = mar_q[ADDR_W-1:0]
WAIT_STATES, 1, extra cycles a RAM access is held before completion (0..15)
CNT_W, 4, width of the wait-state counter; must satisfy WAIT_STATES < 2**CNT_W

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
bus_data  in  DATA_W  datapath bus
MAR_enable  in  1  load MAR from bus_data (IDLE only)
MDR_enable  in  1  load MDR from bus_data (IDLE only)
rd_req  in  1  start read from mem[MAR] (IDLE only)
wr_req  in  1  start write MDR -> mem[MAR] (IDLE only)
mem_rdata  in  DATA_W  RAM read data
mem_ready  in  1  RAM completion; used only with MEM_READY_EN
mar_out  out  DATA_W  MAR contents
mdr_out  out  DATA_W  MDR contents, to bus mux
mem_addr  out  ADDR_W  RAM address, equal to mar_q[ADDR_W-1:0]
mem_wdata  out  DATA_W  equal to mdr_out
mem_re  out  1  RAM read enable
mem_we  out  1  RAM write enable
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
conflict  out  1  one-cycle pulse: rd_req and wr_req both high in IDLE

Behaviour:
- Reset, asynchronous on clear high: state=IDLE; MAR, MDR and counter = 0; mem_re, mem_we, busy, done and conflict all 0. Reset mid-transaction aborts immediately; no MDR capture occurs.
- Three states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state; there are no combinational paths from request inputs to outputs.
- In IDLE:
  - MAR_enable loads MAR; MDR_enable loads MDR. Both may be high in the same cycle, and both load.
  - If a request is high on the same edge as a load, the load takes effect and the transaction uses the newly loaded values.
- Request acceptance, IDLE only:
  - rd_req or wr_req at edge k moves to ACCESS, with cnt=WAIT_STATES and op latched (read/write).
  - rd_req and wr_req together: read is performed, write is dropped, and conflict pulses high in cycle k+1.
- ACCESS:
  - busy=1.
  - Read: mem_re=1 for the whole of ACCESS.
  - Write: mem_we=1 only in the first ACCESS cycle.
  - Each cycle with cnt!=0 decrements cnt.
  - Leaving ACCESS: at the edge where cnt==0, go to DONE; a read captures mem_rdata into MDR on that edge.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Requests in DONE are ignored.
- Latency: a request sampled at edge k gives done high in cycle k+WAIT_STATES+2, and mdr_out valid from that same cycle.
- While not in IDLE: MAR_enable, MDR_enable, rd_req and wr_req are all ignored; MAR and MDR hold.
- mem_addr truncates MAR with no wrap logic; MAR upper bits are retained in mar_out.
- WAIT_STATES=0 gives a single-cycle ACCESS.

Optional Feature:
Macro MEM_READY_EN.
- Defined: ACCESS completes at the first edge where mem_ready=1, instead of on counter expiry. The counter becomes a timeout: if cnt reaches 0 without mem_ready, go to DONE anyway. In that case a read captures nothing, and output timeout pulses high together with done. The timeout port is present only when the macro is defined.
- Undefined: mem_ready is unused and completion is counter-only.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - the op encoding (OP_RD=1'b0, OP_WR=1'b1);
  - the default widths DATA_W=32, ADDR_W=8, CNT_W=4.
- One sub-module is natural: wait_counter, a loadable down-counter with a zero flag, parametrised by CNT_W.
- MAR and MDR are plain registers inside the top module.

Test Plan:
- Reset mid-read, WAIT_STATES=3: clear asserted during ACCESS -> state IDLE, mem_re=0, MDR stays 0, no done pulse.
- Read, WAIT_STATES=1: MAR<=32'h0000_0078 with mem[0x78]=32'hDEAD_BEEF, rd_req at edge k:
  - mem_addr=8'h78;
  - mem_re high in cycles k+1..k+2;
  - done in cycle k+3;
  - mdr_out=32'hDEAD_BEEF.
- Write, WAIT_STATES=2: MAR=0x05, MDR=32'h1234_5678, wr_req:
  - mem_we high for 1 cycle only;
  - busy for 3 cycles;
  - done in cycle k+4;
  - readback returns 32'h1234_5678.
- Conflict and truncation: rd_req and wr_req together with MAR=32'h0000_0105 -> mem_addr=8'h05, read performed, mem_we never high, conflict pulses once.
- Ignore while busy: MAR_enable, MDR_enable and rd_req asserted during ACCESS and DONE -> MAR and MDR unchanged, only one done pulse.
- MEM_READY_EN, WAIT_STATES=4:
  - mem_ready high in the 2nd ACCESS cycle -> done in the next cycle with data captured;
  - mem_ready never high -> timeout and done pulse after 5 ACCESS cycles, with MDR unchanged.
